// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC transmitter and receiver.
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tx_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/bit_sync.sv
// Two-flop level synchronizer for a single asynchronous bit.
module bit_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_data,
  output logic o_data
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= i_data;
      sync_reg <= meta_reg;
    end
  end

  assign o_data = sync_reg;

endmodule

// File: rtl/mb_handshake_tx.sv
// Source-side transmitter of the multibit toggle handshake: a 2-entry input
// buffer feeding a held data bus plus a level-toggle request.
module mb_handshake_tx
  import cdc_pkg::*;
#(
  parameter int NB      = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int NB_CNT  = 16
) (
  input  logic              i_src_clock,
  input  logic              i_reset,
  input  logic [NB-1:0]     i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_ack,
  output logic [NB-1:0]     o_data,
  output logic              o_req,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [NB_CNT-1:0] o_xfer_count
);

  localparam int            TCW   = $clog2(TIMEOUT);
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT - 1);

  // Buffer storage and bookkeeping
  logic [NB-1:0] mem [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    occ_reg;
  logic [1:0]    occ_next;
  logic          ready_reg;
  logic          push;
  logic          pop;

  // Handshake state
  tx_state_t         state_reg, state_next;
  logic              req_reg, req_next;
  logic [NB-1:0]     data_reg, data_next;
  logic [TCW-1:0]    tcnt_reg, tcnt_next;
  logic              timeout_reg, timeout_next;
  logic              done_reg, done_next;
  logic [NB_CNT-1:0] count_reg, count_next;
  logic              ack_sync;

  bit_sync u_ack_sync (
    .i_clock (i_src_clock),
    .i_reset (i_reset),
    .i_data  (i_ack),
    .o_data  (ack_sync)
  );

  assign push = i_valid & ready_reg;

  always_comb begin
    occ_next = occ_reg;
    unique case ({push, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge i_src_clock) begin
    if (i_reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      ready_reg  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg   <= occ_next;
      ready_reg <= (occ_next != 2'd2);
    end
  end

  // Storage is never read before it is written, so it needs no reset.
  always_ff @(posedge i_src_clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  always_comb begin
    state_next   = state_reg;
    req_next     = req_reg;
    data_next    = data_reg;
    tcnt_next    = tcnt_reg;
    timeout_next = timeout_reg;
    done_next    = 1'b0;
    count_next   = count_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (occ_reg != 2'd0) begin
          data_next  = mem[rd_ptr_reg];
          req_next   = ~req_reg;
          pop        = 1'b1;
          tcnt_next  = '0;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_reg) begin
          done_next  = 1'b1;
          count_next = count_reg + NB_CNT'(1);
          state_next = IDLE;
        end else if (tcnt_reg == TLAST) begin
          // The toggle is already out; keep waiting but flag the stall.
          timeout_next = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + TCW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_src_clock) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      req_reg     <= 1'b0;
      data_reg    <= '0;
      tcnt_reg    <= '0;
      timeout_reg <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      data_reg    <= data_next;
      tcnt_reg    <= tcnt_next;
      timeout_reg <= timeout_next;
      done_reg    <= done_next;
      count_reg   <= count_next;
    end
  end

  assign o_ready      = ready_reg;
  assign o_data       = data_reg;
  assign o_req        = req_reg;
  assign o_busy       = (state_reg == WAIT_ACK);
  assign o_done       = done_reg;
  assign o_timeout    = timeout_reg;
  assign o_xfer_count = count_reg;

endmodule

// File: tb/tb_mb_handshake_tx.sv
// Directed bench for mb_handshake_tx: queue-based reference model checked every
// cycle, plus hand-computed expectations per scenario.
module tb_mb_handshake_tx;

  localparam int NB = 8;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        dclk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        ack = 1'b0;

  logic        ready1, req1, busy1, done1, tmo1;
  logic [7:0]  data1;
  logic [15:0] cnt1;
  logic        ready2, req2, busy2, done2, tmo2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  mb_handshake_tx #(.NB(NB), .TIMEOUT(TO), .NB_CNT(16)) dut (
    .i_src_clock (clk),
    .i_reset     (rst),
    .i_data      (din),
    .i_valid     (valid),
    .o_ready     (ready1),
    .i_ack       (ack),
    .o_data      (data1),
    .o_req       (req1),
    .o_busy      (busy1),
    .o_done      (done1),
    .o_timeout   (tmo1),
    .o_xfer_count(cnt1)
  );

  mb_handshake_tx #(.NB(NB), .TIMEOUT(TO), .NB_CNT(2)) dut_w2 (
    .i_src_clock (clk),
    .i_reset     (rst),
    .i_data      (din),
    .i_valid     (valid),
    .o_ready     (ready2),
    .i_ack       (ack),
    .o_data      (data2),
    .o_req       (req2),
    .o_busy      (busy2),
    .o_done      (done2),
    .o_timeout   (tmo2),
    .o_xfer_count(cnt2)
  );

  // Source posedges fall on odd multiples of 5; destination edges are always even.
  always #5 clk = ~clk;
  initial begin
    #2;
    forever begin
      dclk = 1'b1; #7;
      dclk = 1'b0; #7;
    end
  end

  // Destination stand-in: echoes o_req three destination edges later.
  logic ack_auto = 1'b1;
  logic dst_rst  = 1'b1;
  logic s1 = 1'b0, s2 = 1'b0;
  always @(posedge dclk) begin
    if (dst_rst) begin
      s1 = 1'b0; s2 = 1'b0; ack = 1'b0;
    end else if (ack_auto) begin
      ack = s2; s2 = s1; s1 = req1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending words, a waiting flag, a 2-edge ack delay.
  logic [7:0] q[$];
  logic [7:0] m_data = 8'h00;
  bit  m_req = 0, m_wait = 0, m_done = 0, m_tmo = 0, m_a1 = 0, m_a2 = 0;
  int  m_wcnt = 0, m_count = 0;

  always @(posedge clk) begin : model
    bit push;
    if (rst) begin
      q.delete();
      m_req = 0; m_data = 8'h00; m_wait = 0; m_done = 0; m_tmo = 0;
      m_a1 = 0; m_a2 = 0; m_wcnt = 0; m_count = 0;
    end else begin
      push = valid && (q.size() < 2);
      m_done = 0;
      if (!m_wait) begin
        if (q.size() > 0) begin
          m_data = q.pop_front();
          m_req  = !m_req;
          m_wait = 1;
          m_wcnt = 0;
        end
      end else if (m_a2 == m_req) begin
        m_wait = 0;
        m_done = 1;
        m_count++;
      end else begin
        m_wcnt++;
        if (m_wcnt >= TO) m_tmo = 1;
      end
      if (push) q.push_back(din);
      m_a2 = m_a1;
      m_a1 = ack;
    end
  end

  // Per-cycle comparison and log of words sent on each request toggle.
  bit         cmp_on = 0;
  logic       prev_req = 1'b0;
  logic [7:0] sent[$];
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("req",     req1,   m_req);
      chk("data",    data1,  m_data);
      chk("ready",   ready1, (q.size() < 2));
      chk("busy",    busy1,  m_wait);
      chk("done",    done1,  m_done);
      chk("timeout", tmo1,   m_tmo);
      chk("count",   cnt1,   m_count & 16'hFFFF);
      chk("w2_req",  req2,   m_req);
      chk("w2_data", data2,  m_data);
      chk("w2_ready", ready2, (q.size() < 2));
      chk("w2_busy", busy2,  m_wait);
      chk("w2_done", done2,  m_done);
      chk("w2_timeout", tmo2, m_tmo);
      chk("w2_count", cnt2,  m_count & 3);
      if (req1 !== prev_req) sent.push_back(data1);
      prev_req = req1;
      if (done1) $display("xfer complete: data=%02h count=%0d count2=%0d", data1, cnt1, cnt2);
    end
  end

  task automatic send(input logic [7:0] d);
    valid = 1'b1;
    din   = d;
    @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (done1) got++;
    end
    chk(nm, got, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dst_rst = 1'b0;
    cmp_on = 1;
    chk("reset_req", req1, 0);
    chk("reset_data", data1, 0);
    chk("reset_ready", ready1, 1);
    chk("reset_count", cnt1, 0);

    // Single word
    sent.delete();
    send(8'hA5);
    valid = 1'b0;
    @(negedge clk);
    chk("single_req", req1, 1);
    chk("single_data", data1, 8'hA5);
    wait_done(1, 60, "single_done");
    chk("single_count", cnt1, 1);

    // Back-to-back burst
    sent.delete();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    valid = 1'b0;
    chk("burst_ready_low", ready1, 0);
    wait_done(3, 300, "burst_done");
    chk("burst_nsent", sent.size(), 3);
    chk("burst_w0", sent[0], 8'h11);
    chk("burst_w1", sent[1], 8'h22);
    chk("burst_w2", sent[2], 8'h33);
    chk("burst_count", cnt1, 4);

    // Stalled acknowledge
    ack_auto = 1'b0;
    send(8'h77);
    valid = 1'b0;
    @(negedge clk);
    chk("stall_data", data1, 8'h77);
    chk("stall_busy", busy1, 1);
    repeat (TO - 1) @(negedge clk);
    chk("timeout_before", tmo1, 0);
    @(negedge clk);
    chk("timeout_at", tmo1, 1);
    chk("stall_data_held", data1, 8'h77);
    ack_auto = 1'b1;
    wait_done(1, 100, "stall_done");
    chk("timeout_sticky", tmo1, 1);
    chk("count_5", cnt1, 5);
    chk("w2_wrap", cnt2, 1);

    // Valid while full
    ack_auto = 1'b0;
    sent.delete();
    send(8'h44);
    send(8'h55);
    send(8'h66);
    send(8'hFF);
    send(8'hFF);
    valid = 1'b0;
    chk("full_ready", ready1, 0);
    ack_auto = 1'b1;
    wait_done(3, 400, "full_done");
    repeat (20) @(negedge clk);
    chk("full_nsent", sent.size(), 3);
    chk("full_w0", sent[0], 8'h44);
    chk("full_w1", sent[1], 8'h55);
    chk("full_w2", sent[2], 8'h66);
    chk("full_count", cnt1, 8);

    // Reset mid-transfer with a buffered word
    ack_auto = 1'b0;
    send(8'h88);
    send(8'h99);
    valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", busy1, 1);
    rst = 1'b1;
    dst_rst = 1'b1;
    @(negedge clk);
    chk("rst_req", req1, 0);
    chk("rst_data", data1, 0);
    chk("rst_ready", ready1, 1);
    chk("rst_count", cnt1, 0);
    chk("rst_timeout", tmo1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dst_rst = 1'b0;
    ack_auto = 1'b1;
    sent.delete();
    repeat (30) @(negedge clk);
    chk("post_reset_toggles", sent.size(), 0);
    chk("post_reset_busy", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
